dmem_banked: RTL and testbench

Parametrised data memory that succeeds the fixed-size single-port dmem. It provides one read port and one write port. It adds:
- per-byte write enables
- a selectable combinational or registered read path
- write-first read-during-write forwarding
- a hardware clear engine that zeroes the array after reset or on request
It sits between the PE datapath and the memory-mapped load/store unit.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_banked_if.sv | 32 +++
 rtl/dmem_clr_fsm.sv | 64 ++++++
 rtl/dmem_banked.sv | 133 +++++++++++++
 tb/tb_dmem_banked.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the banked data memory: FSM encoding, default widths
// and the byte-merge helper used by both the write path and read forwarding.
package dmem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } dmem_state_e;

  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_ADDR_W = 8;

  // Widest word the merge helper handles; callers widen and truncate around it.
  localparam int unsigned DMEM_MAX_W  = 256;
  localparam int unsigned DMEM_MAX_BE = DMEM_MAX_W / 8;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w.
  function automatic logic [DMEM_MAX_W-1:0] merge_be(input logic [DMEM_MAX_W-1:0]  old_w,
                                                     input logic [DMEM_MAX_W-1:0]  new_w,
                                                     input logic [DMEM_MAX_BE-1:0] be);
    logic [DMEM_MAX_W-1:0] res;
    res = old_w;
    for (int k = 0; k < DMEM_MAX_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_banked_if.sv
// Load/store bus between the PE datapath and dmem_banked: one read port, one
// byte-enabled write port, clear request and status.
interface dmem_banked_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) ();

  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_clr;
  logic              i_re;
  logic [ADDR_W-1:0] i_a;
  logic [DATA_W-1:0] o_rd;
  logic              o_rvalid;
  logic              i_we;
  logic [ADDR_W-1:0] i_b;
  logic [DATA_W-1:0] i_wd;
  logic [BE_W-1:0]   i_be;
  logic              o_busy;
  logic              o_perr;

  modport master (
    output i_clr, i_re, i_a, i_we, i_b, i_wd, i_be,
    input  o_rd, o_rvalid, o_busy, o_perr
  );

  modport slave (
    input  i_clr, i_re, i_a, i_we, i_b, i_wd, i_be,
    output o_rd, o_rvalid, o_busy, o_perr
  );

endinterface

// File: rtl/dmem_clr_fsm.sv
// Clear engine: walks the array once writing zeros, after reset or on request.
// Reports busy while walking and supplies the clear write address/enable.
module dmem_clr_fsm
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and counter registers; reset lands in CLEAR with the counter at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: requests only honoured in IDLE; CLEAR exits after the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == LastAddr) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  // No array write while reset is held.
  assign clr_we   = busy & ~rst;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/dmem_banked.sv
// Parametrised data memory: one read port, one byte-enabled write port,
// combinational or registered read (REG_RD), write-first forwarding on the
// registered path, and a hardware clear engine.
// Optional per-byte even parity storage is enabled by defining DMEM_PARITY_EN.
module dmem_banked
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned REG_RD = 1
) (
  input logic          clk,
  input logic          rst,
  dmem_banked_if.slave bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [IDX_W-1:0]  a_idx, b_idx, c_idx;
  logic              a_ok, b_ok;
  logic              user_we;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_raw;
  logic [BE_W-1:0]   par_mis;

  dmem_clr_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.i_clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign a_ok  = 32'(bus.i_a) < DEPTH;
  assign b_ok  = 32'(bus.i_b) < DEPTH;
  assign a_idx = bus.i_a[IDX_W-1:0];
  assign b_idx = bus.i_b[IDX_W-1:0];
  assign c_idx = clr_addr[IDX_W-1:0];

  // Out-of-range writes and all-zero byte enables never touch the array.
  assign user_we = ~busy & ~rst & bus.i_we & b_ok & (|bus.i_be);

  assign wr_word = DATA_W'(merge_be(DMEM_MAX_W'(mem_q[b_idx]), DMEM_MAX_W'(bus.i_wd),
                                    DMEM_MAX_BE'(bus.i_be)));

  assign rd_raw = a_ok ? mem_q[a_idx] : '0;

  // Array write port, shared between the clear engine and the user write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[c_idx] <= '0;
    end else if (user_we) begin
      mem_q[b_idx] <= wr_word;
    end
  end

`ifdef DMEM_PARITY_EN
  logic [BE_W-1:0] par_q [DEPTH];
  logic [BE_W-1:0] par_wr;

  // New parity for written bytes; untouched bytes keep their stored parity.
  always_comb begin
    par_wr  = '0;
    par_mis = '0;
    for (int k = 0; k < BE_W; k++) begin
      par_wr[k]  = bus.i_be[k] ? ^bus.i_wd[8*k +: 8] : par_q[b_idx][k];
      par_mis[k] = a_ok & (par_q[a_idx][k] ^ (^mem_q[a_idx][8*k +: 8]));
    end
  end

  // Parity store follows the data array; clear stores parity 0.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      par_q[c_idx] <= '0;
    end else if (user_we) begin
      par_q[b_idx] <= par_wr;
    end
  end
`else
  assign par_mis = '0;
`endif

  assign bus.o_busy = busy;

  if (REG_RD != 0) begin : g_rd_reg
    logic              hit;
    logic [BE_W-1:0]   fwd_be;
    logic [DATA_W-1:0] rd_q;
    logic              rvalid_q;
    logic              perr_q;

    // Write-first: a same-address write in this cycle replaces its enabled bytes.
    assign hit    = bus.i_we & a_ok & (bus.i_a == bus.i_b);
    assign fwd_be = hit ? bus.i_be : '0;

    // Registered read; o_rd holds when no read is accepted.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q     <= '0;
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
      end else if (~busy & bus.i_re) begin
        rd_q     <= hit ? wr_word : rd_raw;
        rvalid_q <= 1'b1;
        // Forwarded bytes carry fresh data, so only stored bytes can flag.
        perr_q   <= |(par_mis & ~fwd_be);
      end else begin
        rvalid_q <= 1'b0;
        perr_q   <= 1'b0;
      end
    end

    assign bus.o_rd     = rd_q;
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_perr   = perr_q;
  end else begin : g_rd_comb
    assign bus.o_rd     = rd_raw;
    assign bus.o_rvalid = bus.i_re & ~busy;
    assign bus.o_perr   = bus.i_re & ~busy & (|par_mis);
  end

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: a registered-read and a combinational-read
// instance share one stimulus stream and one behavioural memory model.
module tb_dmem_banked;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr, re, we;
  logic [7:0]  a, b;
  logic [31:0] wd;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;

  // Behavioural model: word contents, bytes known to carry bad parity,
  // cycles of clearing still to go, and expected registered-port outputs.
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_bad [DEPTH];
  int          clear_left;
  logic [31:0] e_rd;
  logic        e_rvalid, e_perr;
  bit          started = 1'b0;

  dmem_banked_if #(.DATA_W(32), .ADDR_W(8)) bus_r ();
  dmem_banked_if #(.DATA_W(32), .ADDR_W(8)) bus_c ();

  assign bus_r.i_clr = clr;
  assign bus_r.i_re  = re;
  assign bus_r.i_a   = a;
  assign bus_r.i_we  = we;
  assign bus_r.i_b   = b;
  assign bus_r.i_wd  = wd;
  assign bus_r.i_be  = be;
  assign bus_c.i_clr = clr;
  assign bus_c.i_re  = re;
  assign bus_c.i_a   = a;
  assign bus_c.i_we  = we;
  assign bus_c.i_b   = b;
  assign bus_c.i_wd  = wd;
  assign bus_c.i_be  = be;

  dmem_banked #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .REG_RD(1)) dut_r (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  dmem_banked #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .REG_RD(0)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // One clock cycle: check combinational outputs, advance the model, take the
  // edge, then check registered outputs.
  task automatic step();
    logic [31:0] nw;
    logic [3:0]  fmask;
    #1;
    if (started) begin
      chk("busy_r", {31'd0, bus_r.o_busy}, {31'd0, clear_left > 0});
      chk("busy_c", {31'd0, bus_c.o_busy}, {31'd0, clear_left > 0});
      chk("rvalid_c", {31'd0, bus_c.o_rvalid}, {31'd0, re && clear_left == 0});
      if (re && clear_left == 0) begin
        chk("rd_c", bus_c.o_rd, m_mem[a]);
        chk("perr_c", {31'd0, bus_c.o_perr}, {31'd0, |m_bad[a]});
      end
    end
    if (rst) begin
      clear_left = DEPTH;
      e_rd       = '0;
      e_rvalid   = 1'b0;
      e_perr     = 1'b0;
      started    = 1'b1;
    end else if (clear_left > 0) begin
      m_mem[DEPTH-clear_left] = '0;
      m_bad[DEPTH-clear_left] = '0;
      clear_left--;
      e_rvalid = 1'b0;
      e_perr   = 1'b0;
    end else begin
      nw = m_mem[b];
      for (int k = 0; k < 4; k++) if (be[k]) nw[8*k +: 8] = wd[8*k +: 8];
      fmask = '0;
      if (re) begin
        if (we && a == b) begin
          e_rd  = nw;
          fmask = be;
        end else begin
          e_rd = m_mem[a];
        end
        e_perr   = |(m_bad[a] & ~fmask);
        e_rvalid = 1'b1;
      end else begin
        e_rvalid = 1'b0;
        e_perr   = 1'b0;
      end
      if (we) begin
        m_mem[b] = nw;
        m_bad[b] = m_bad[b] & ~be;
      end
      if (clr) clear_left = DEPTH;
    end
    @(posedge clk);
    #1;
    if (started) begin
      chk("rvalid_r", {31'd0, bus_r.o_rvalid}, {31'd0, e_rvalid});
      chk("rd_r", bus_r.o_rd, e_rd);
      chk("perr_r", {31'd0, bus_r.o_perr}, {31'd0, e_perr});
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] en);
    b  = addr;
    wd = data;
    be = en;
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr);
    a  = addr;
    re = 1'b1;
    step();
    re = 1'b0;
  endtask

  // Count consecutive busy cycles starting now, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus_r.o_busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_bad[i] = '0;
    end
    clear_left = 0;
    rst = 1'b1; clr = 1'b0; re = 1'b0; we = 1'b0;
    a = '0; b = '0; wd = '0; be = '0;

    // Reset clear: three cycles of reset, then a full DEPTH-cycle sweep.
    repeat (3) step();
    chk("rst_rd", bus_r.o_rd, 32'h0);
    chk("rst_rvalid", {31'd0, bus_r.o_rvalid}, 32'd0);
    chk("rst_busy", {31'd0, bus_r.o_busy}, 32'd1);
    chk("rst_perr", {31'd0, bus_r.o_perr}, 32'd0);
    rst = 1'b0;
    count_busy(n);
    chk("reset_clear_len", n, DEPTH);
    rd(8'h00);
    chk("t1_rd00", bus_r.o_rd, 32'h0000_0000);
    rd(8'hFF);
    chk("t1_rdff", bus_r.o_rd, 32'h0000_0000);
    chk("t1_rvalid", {31'd0, bus_r.o_rvalid}, 32'd1);

    // Byte write merge.
    wr(8'h10, 32'hAABB_CCDD, 4'b1111);
    wr(8'h10, 32'h1122_3344, 4'b0101);
    wr(8'h10, 32'hDEAD_BEEF, 4'b0000);
    chk("t2_rvalid_idle", {31'd0, bus_r.o_rvalid}, 32'd0);
    rd(8'h10);
    chk("t2_merge", bus_r.o_rd, 32'hAA22_CC44);
    chk("t2_rvalid", {31'd0, bus_r.o_rvalid}, 32'd1);

    // Read-during-write to the same address.
    wr(8'h20, 32'h0102_0304, 4'b1111);
    we = 1'b1; re = 1'b1; a = 8'h20; b = 8'h20; wd = 32'hFFFF_FFFF; be = 4'b1000;
    #1;
    chk("t3_comb_old", bus_c.o_rd, 32'h0102_0304);
    step();
    we = 1'b0; re = 1'b0;
    chk("t3_reg_fwd", bus_r.o_rd, 32'hFF02_0304);

    // Clear on request; accesses during the sweep are dropped.
    for (int i = 0; i < 4; i++) wr(8'(i), 32'h1111_1111 * (i + 1), 4'b1111);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_busy_rise", {31'd0, bus_r.o_busy}, 32'd1);
    n = 0;
    while (bus_r.o_busy === 1'b1 && n < 400) begin
      re = 1'b1; a = 8'(n % 4);
      we = 1'b1; b = 8'h05; wd = $urandom; be = 4'b1111;
      step();
      n++;
    end
    re = 1'b0; we = 1'b0;
    chk("t4_clear_len", n, DEPTH);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      chk("t4_zero", bus_r.o_rd, 32'h0);
    end
    rd(8'h05);
    chk("t4_drop_wr", bus_r.o_rd, 32'h0);

    // Reset part-way through a clear restarts the sweep.
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (100) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    chk("t5_restart_len", n, DEPTH);

    // Randomised traffic, occasional clear requests.
    for (int i = 0; i < 600; i++) begin
      re  = 1'($urandom);
      we  = 1'($urandom);
      a   = 8'($urandom_range(0, 15));
      b   = 8'($urandom_range(0, 15));
      wd  = $urandom;
      be  = 4'($urandom);
      clr = ($urandom_range(0, 199) == 0);
      step();
    end
    re = 1'b0; we = 1'b0; clr = 1'b0;
    count_busy(n);
    chk("rand_settle", {31'd0, bus_r.o_busy}, 32'd0);

`ifdef DMEM_PARITY_EN
    // Corrupt one stored byte behind the parity bit's back.
    wr(8'h30, 32'h1234_5678, 4'b1111);
    dut_r.mem_q[8'h30] = dut_r.mem_q[8'h30] ^ 32'h0001_0000;
    dut_c.mem_q[8'h30] = dut_c.mem_q[8'h30] ^ 32'h0001_0000;
    m_mem[8'h30] = m_mem[8'h30] ^ 32'h0001_0000;
    m_bad[8'h30] = 4'b0100;
    a = 8'h30; re = 1'b1;
    #1;
    chk("t6_perr_comb", {31'd0, bus_c.o_perr}, 32'd1);
    step();
    re = 1'b0;
    chk("t6_perr_reg", {31'd0, bus_r.o_perr}, 32'd1);
    chk("t6_rvalid", {31'd0, bus_r.o_rvalid}, 32'd1);
    rd(8'h31);
    chk("t6_perr_clean", {31'd0, bus_r.o_perr}, 32'd0);
`else
    rd(8'h30);
    chk("perr_tied", {31'd0, bus_r.o_perr}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
